// File: rtl/cpu_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bridge_pkg
// Description : Shared types and helpers for the CPU pin-bus to req/ack bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } bridge_state_t;

    localparam logic MEM_AREA = 1'b1;
    localparam logic IO_AREA  = 1'b0;

    // A bus cycle that should reach a responder: memory or I/O strobe with a
    // read or write strobe, excluding refresh and interrupt acknowledge.
    function automatic logic is_valid_access(
        input logic mreq_n,
        input logic iorq_n,
        input logic rd_n,
        input logic wr_n,
        input logic m1_n,
        input logic rfsh_n
    );
        logic refresh;
        logic intack;
        refresh = !mreq_n && !rfsh_n;
        intack  = !m1_n && !iorq_n;
        return (!mreq_n || !iorq_n) && (!rd_n || !wr_n) && !refresh && !intack;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_bus_sampler.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_sampler
// Description : Registers the CPU strobes, address and write data on the
//               system clock. Strobes reset to their inactive (high) level.
//               o_loaded flags that the registers hold real pin samples.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_sampler
    import cpu_bridge_pkg::*;
#(
    parameter int ADR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_mreq_n,
    input  logic             i_iorq_n,
    input  logic             i_rd_n,
    input  logic             i_wr_n,
    input  logic             i_m1_n,
    input  logic             i_rfsh_n,
    input  logic [ADR_W-1:0] i_a,
    input  logic [7:0]       i_dw,
    output logic             o_mreq_n,
    output logic             o_iorq_n,
    output logic             o_rd_n,
    output logic             o_wr_n,
    output logic             o_m1_n,
    output logic             o_rfsh_n,
    output logic [ADR_W-1:0] o_a,
    output logic [7:0]       o_dw,
    output logic             o_loaded
);

    logic [5:0]       r_strb;
    logic [ADR_W-1:0] r_a;
    logic [7:0]       r_dw;
    logic             r_loaded;

    // Sample every pin on every clock; strobes idle high out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strb   <= 6'b11_1111;
            r_a      <= '0;
            r_dw     <= 8'h00;
            r_loaded <= 1'b0;
        end else begin
            r_strb   <= {i_mreq_n, i_iorq_n, i_rd_n, i_wr_n, i_m1_n, i_rfsh_n};
            r_a      <= i_a;
            r_dw     <= i_dw;
            r_loaded <= 1'b1;
        end
    end

    assign {o_mreq_n, o_iorq_n, o_rd_n, o_wr_n, o_m1_n, o_rfsh_n} = r_strb;
    assign o_a      = r_a;
    assign o_dw     = r_dw;
    assign o_loaded = r_loaded;

endmodule
`default_nettype wire

// File: rtl/cpu_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_bridge
// Description : Converts Z80/R800 MREQ/IORQ/RD/WR bus cycles into a single
//               req/ack request per CPU cycle and returns read data.
//               Optional macro CPU_BRIDGE_WAIT_EN: hold WAIT low while the
//               request is outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_bridge
    import cpu_bridge_pkg::*;
#(
    parameter int ADR_W = 16
) (
    input  logic             clk21m,
    input  logic             n_reset,
    input  logic             n_mreq,
    input  logic             n_iorq,
    input  logic             n_rd,
    input  logic             n_wr,
    input  logic             n_m1,
    input  logic             n_rfsh,
    input  logic [ADR_W-1:0] cpu_a,
    input  logic [7:0]       cpu_dw,
    output logic [7:0]       cpu_dr,
    output logic             cpu_doe,
    output logic             n_wait,
    output logic             req,
    input  logic             ack,
    output logic             mem,
    output logic             wrt,
    output logic [ADR_W-1:0] adr,
    output logic [7:0]       dbo,
    input  logic [7:0]       dbi
);

    logic             w_mreq_n, w_iorq_n, w_rd_n, w_wr_n, w_m1_n, w_rfsh_n;
    logic [ADR_W-1:0] w_a;
    logic [7:0]       w_dw;
    logic             w_loaded;

    cpu_bus_sampler #(.ADR_W(ADR_W)) u_sampler (
        .clk      (clk21m),
        .rst_n    (n_reset),
        .i_mreq_n (n_mreq),
        .i_iorq_n (n_iorq),
        .i_rd_n   (n_rd),
        .i_wr_n   (n_wr),
        .i_m1_n   (n_m1),
        .i_rfsh_n (n_rfsh),
        .i_a      (cpu_a),
        .i_dw     (cpu_dw),
        .o_mreq_n (w_mreq_n),
        .o_iorq_n (w_iorq_n),
        .o_rd_n   (w_rd_n),
        .o_wr_n   (w_wr_n),
        .o_m1_n   (w_m1_n),
        .o_rfsh_n (w_rfsh_n),
        .o_a      (w_a),
        .o_dw     (w_dw),
        .o_loaded (w_loaded)
    );

    bridge_state_t    r_state, w_nxt;
    logic             w_valid, w_bus_idle, w_req, w_wait_n;
    logic             r_post_rst;
    logic             r_dvalid;
    logic             r_mem, r_wrt;
    logic [ADR_W-1:0] r_adr;
    logic [7:0]       r_dbo, r_dr;

    assign w_valid    = is_valid_access(w_mreq_n, w_iorq_n, w_rd_n, w_wr_n, w_m1_n, w_rfsh_n);
    assign w_bus_idle = w_mreq_n && w_iorq_n;

    // State register.
    always_ff @(posedge clk21m or negedge n_reset) begin
        if (!n_reset) r_state <= ST_IDLE;
        else          r_state <= w_nxt;
    end

    // Next state, request and WAIT generation.
    always_comb begin
        w_nxt    = r_state;
        w_req    = 1'b0;
        w_wait_n = 1'b1;
        case (r_state)
            ST_IDLE: begin
                // Right after reset a CPU cycle may already be in progress;
                // park in ST_HOLD until its strobes release.
                if (r_post_rst) begin
                    if (w_loaded && !w_bus_idle) w_nxt = ST_HOLD;
                end else if (w_valid) begin
                    w_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                w_req = 1'b1;
`ifdef CPU_BRIDGE_WAIT_EN
                w_wait_n = 1'b0;
`endif
                if (ack)             w_nxt = ST_HOLD;
                else if (w_bus_idle) w_nxt = ST_IDLE;
            end
            ST_HOLD: begin
                if (w_bus_idle) w_nxt = ST_IDLE;
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    // Request attributes, read data and post-reset guard.
    always_ff @(posedge clk21m or negedge n_reset) begin
        if (!n_reset) begin
            r_post_rst <= 1'b1;
            r_dvalid   <= 1'b0;
            r_mem      <= MEM_AREA;
            r_wrt      <= 1'b0;
            r_adr      <= '0;
            r_dbo      <= 8'h00;
            r_dr       <= 8'h00;
        end else begin
            if (r_post_rst && w_loaded) r_post_rst <= 1'b0;
            if (r_state == ST_IDLE && w_nxt == ST_REQ) begin
                r_adr <= w_a;
                r_mem <= w_iorq_n ? MEM_AREA : IO_AREA;
                r_wrt <= !w_wr_n;
                r_dbo <= w_dw;
            end
            if (r_state == ST_REQ && ack && !r_wrt) begin
                r_dr     <= dbi;
                r_dvalid <= 1'b1;
            end
            if (r_state == ST_HOLD && w_bus_idle) r_dvalid <= 1'b0;
        end
    end

    assign req     = w_req;
    assign n_wait  = w_wait_n;
    assign mem     = r_mem;
    assign wrt     = r_wrt;
    assign adr     = r_adr;
    assign dbo     = r_dbo;
    assign cpu_dr  = r_dr;
    // Raw pins so the data drive drops the moment RD or the cycle ends.
    assign cpu_doe = !n_rd && (!n_mreq || !n_iorq) && r_dvalid && !(!n_m1 && !n_iorq);

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_bus_bridge
// Description : Self-checking bench for cpu_bus_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_bridge;

    logic        clk21m = 1'b0;
    logic        n_reset = 1'b1;
    logic        n_mreq = 1'b1, n_iorq = 1'b1, n_rd = 1'b1, n_wr = 1'b1;
    logic        n_m1 = 1'b1, n_rfsh = 1'b1;
    logic [15:0] cpu_a = 16'h0;
    logic [7:0]  cpu_dw = 8'h0;
    logic [7:0]  cpu_dr;
    logic        cpu_doe, n_wait, req, mem, wrt;
    logic        ack = 1'b0;
    logic [15:0] adr;
    logic [7:0]  dbo;
    logic [7:0]  dbi = 8'h0;

    int n_checks = 0;
    int n_err    = 0;
    logic [7:0] model_dr;

    cpu_bus_bridge #(.ADR_W(16)) dut (
        .clk21m (clk21m), .n_reset(n_reset),
        .n_mreq (n_mreq), .n_iorq (n_iorq), .n_rd(n_rd), .n_wr(n_wr),
        .n_m1   (n_m1),   .n_rfsh (n_rfsh),
        .cpu_a  (cpu_a),  .cpu_dw (cpu_dw), .cpu_dr(cpu_dr), .cpu_doe(cpu_doe),
        .n_wait (n_wait), .req    (req),    .ack(ack),
        .mem    (mem),    .wrt    (wrt),    .adr(adr), .dbo(dbo), .dbi(dbi)
    );

    always #5 clk21m = ~clk21m;

    typedef struct {
        logic        is_mem;
        logic        is_wr;
        logic [15:0] addr;
        logic [7:0]  data;
        int          dly;
        int          exp_req;
        logic        exp_mem;
        logic        exp_wrt;
        logic [15:0] exp_adr;
        logic [7:0]  exp_dbo;
        logic [7:0]  exp_dr;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk21m);
        #1;
    endtask

    task automatic pins_idle();
        n_mreq = 1'b1; n_iorq = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
        n_m1 = 1'b1;   n_rfsh = 1'b1;
    endtask

    task automatic pins_cycle(input logic is_mem, input logic is_wr,
                              input logic [15:0] a, input logic [7:0] d);
        n_mreq = !is_mem; n_iorq = is_mem;
        n_rd = is_wr;     n_wr = !is_wr;
        n_m1 = 1'b1;      n_rfsh = 1'b1;
        cpu_a = a;        cpu_dw = d;
    endtask

    // One complete CPU cycle with a responder acking in req cycle 'dly'.
    task automatic run_txn(input vec_t v);
        int cnt, first, waitlow, extra, exp_wait;
        bit done;
        cnt = 0; first = -1; waitlow = 0; extra = 0; done = 0;
        ack = 1'b0;
        pins_cycle(v.is_mem, v.is_wr, v.addr, v.data);
        for (int cyc = 0; cyc < v.dly + 30 && !done; cyc++) begin
            tick();
            if (!n_wait) waitlow++;
            if (req) begin
                if (cnt == 0) begin
                    first = cyc;
                    chk("adr", 32'(adr), 32'(v.exp_adr));
                    chk("mem", 32'(mem), 32'(v.exp_mem));
                    chk("wrt", 32'(wrt), 32'(v.exp_wrt));
                    chk("dbo", 32'(dbo), 32'(v.exp_dbo));
                end
                cnt++;
                ack = (cnt - 1 == v.dly);
                dbi = v.is_wr ? ~v.data : v.data;
            end else begin
                ack = 1'b0;
                if (cnt > 0) done = 1;
            end
        end
        ack = 1'b0;
        chk("req_timeout", 32'(done), 32'd1);
        chk("req_latency", 32'(first), 32'd1);
        chk("req_cycles", 32'(cnt), 32'(v.exp_req));
        for (int i = 0; i < 4; i++) begin
            tick();
            if (req) extra++;
            if (!n_wait) waitlow++;
        end
        chk("second_req", 32'(extra), 32'd0);
`ifdef CPU_BRIDGE_WAIT_EN
        exp_wait = v.exp_req;
`else
        exp_wait = 0;
`endif
        chk("wait_cycles", 32'(waitlow), 32'(exp_wait));
        chk("cpu_dr", 32'(cpu_dr), 32'(v.exp_dr));
        chk("doe_active", 32'(cpu_doe), 32'(!v.is_wr));
        pins_idle();
        #1;
        chk("doe_release", 32'(cpu_doe), 32'd0);
        repeat (3) tick();
    endtask

    task automatic wait_req(output bit seen);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (req) seen = 1;
        end
    endtask

    initial begin
        vec_t v;
        bit   seen;
        int   cnt;

        // Test-plan vectors; expected values written out by hand.
        tbl[0] = '{1'b1, 1'b0, 16'h1234, 8'h3E, 2,  3,  1'b1, 1'b0, 16'h1234, 8'h3E, 8'h3E};
        tbl[1] = '{1'b0, 1'b1, 16'h00E4, 8'h06, 0,  1,  1'b0, 1'b1, 16'h00E4, 8'h06, 8'h3E};
        tbl[2] = '{1'b0, 1'b0, 16'h00E5, 8'h5A, 10, 11, 1'b0, 1'b0, 16'h00E5, 8'h5A, 8'h5A};
        tbl[3] = '{1'b1, 1'b1, 16'h8000, 8'hA5, 1,  2,  1'b1, 1'b1, 16'h8000, 8'hA5, 8'h5A};

        #1 n_reset = 1'b0;
        #2;
        chk("rst_req",  32'(req),     32'd0);
        chk("rst_wrt",  32'(wrt),     32'd0);
        chk("rst_doe",  32'(cpu_doe), 32'd0);
        chk("rst_mem",  32'(mem),     32'd1);
        chk("rst_wait", 32'(n_wait),  32'd1);
        chk("rst_adr",  32'(adr),     32'd0);
        chk("rst_dbo",  32'(dbo),     32'd0);
        chk("rst_dr",   32'(cpu_dr),  32'd0);
        repeat (2) tick();
        n_reset = 1'b1;
        repeat (4) tick();
        model_dr = 8'h00;

        for (int i = 0; i < 4; i++) begin
            run_txn(tbl[i]);
            if (!tbl[i].is_wr) model_dr = tbl[i].data;
        end

        // Refresh cycle: no request even with RD low.
        n_mreq = 1'b0; n_rfsh = 1'b0; n_rd = 1'b0;
        cnt = 0;
        repeat (6) begin tick(); if (req || !n_wait) cnt++; end
        chk("refresh_req", 32'(cnt), 32'd0);
        pins_idle(); repeat (3) tick();

        // Interrupt acknowledge: no request, no data drive.
        n_m1 = 1'b0; n_iorq = 1'b0; n_rd = 1'b0;
        cnt = 0;
        repeat (6) begin tick(); if (req || cpu_doe) cnt++; end
        chk("intack_req", 32'(cnt), 32'd0);
        pins_idle(); repeat (3) tick();

        // Stray ack while idle must not touch read data.
        ack = 1'b1; dbi = 8'hC3;
        repeat (2) tick();
        ack = 1'b0;
        tick();
        chk("stray_ack_dr", 32'(cpu_dr), 32'(model_dr));
        chk("stray_ack_req", 32'(req), 32'd0);

        // Abort: strobes released while the request is still unanswered.
        pins_cycle(1'b1, 1'b0, 16'h4321, 8'h00);
        dbi = 8'h99;
        wait_req(seen);
        chk("abort_req_seen", 32'(seen), 32'd1);
        tick();
        pins_idle();
        repeat (2) tick();
        chk("abort_req", 32'(req), 32'd0);
        chk("abort_dr", 32'(cpu_dr), 32'(model_dr));
        chk("abort_wait", 32'(n_wait), 32'd1);
        cnt = 0;
        repeat (3) begin tick(); if (req) cnt++; end
        chk("abort_no_req", 32'(cnt), 32'd0);

        // Reset while a request is outstanding.
        pins_cycle(1'b0, 1'b0, 16'h0055, 8'h00);
        wait_req(seen);
        chk("rstmid_req_seen", 32'(seen), 32'd1);
        n_reset = 1'b0;
        #1;
        chk("rstmid_req",  32'(req),    32'd0);
        chk("rstmid_wait", 32'(n_wait), 32'd1);
        chk("rstmid_adr",  32'(adr),    32'd0);
        chk("rstmid_mem",  32'(mem),    32'd1);
        repeat (2) tick();
        n_reset = 1'b1;
        model_dr = 8'h00;
        cnt = 0;
        repeat (6) begin tick(); if (req) cnt++; end
        chk("rstmid_no_req", 32'(cnt), 32'd0);
        pins_idle(); repeat (3) tick();

        // Randomized cycles against a spec-level model.
        for (int i = 0; i < 40; i++) begin
            v.is_mem  = 1'($urandom_range(0, 1));
            v.is_wr   = 1'($urandom_range(0, 1));
            v.addr    = 16'($urandom);
            v.data    = 8'($urandom);
            v.dly     = $urandom_range(0, 5);
            v.exp_req = v.dly + 1;
            v.exp_mem = v.is_mem;
            v.exp_wrt = v.is_wr;
            v.exp_adr = v.addr;
            v.exp_dbo = v.data;
            if (!v.is_wr) model_dr = v.data;
            v.exp_dr  = model_dr;
            run_txn(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
